// File: rtl/dff_pipe_bank.sv
// Scan-capable WIDTH x DEPTH register pipeline with per-stage valid bits,
// flush, clock enable, complementary outputs and occupancy count.
module dff_pipe_bank #(
  parameter int unsigned       WIDTH     = 4,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                           CLK,
  input  logic                           RESET_B,
  input  logic                           EN,
  input  logic                           SE,
  input  logic                           SI,
  input  logic                           FLUSH,
  input  logic [WIDTH-1:0]               D,
  input  logic                           VALID_IN,
  output logic [WIDTH-1:0]               Q,
  output logic [WIDTH-1:0]               QB,
  output logic                           VALID_OUT,
  output logic                           SO,
  output logic [$clog2(DEPTH+1)-1:0]     OCC
);

  localparam int unsigned N  = WIDTH * DEPTH;
  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d, adv_data;
  logic [DEPTH-1:0]            vld_q, vld_d, adv_vld;
  logic [N-1:0]                chain, chain_shift;
  logic [OW-1:0]               occ;

  // Flattened chain index is k*WIDTH+b, so SI enters at stage0[0].
  always_comb begin
    chain          = stage_q;
    chain_shift    = '0;
    chain_shift[0] = SI;
    for (int unsigned i = 1; i < N; i++) begin
      chain_shift[i] = chain[i-1];
    end
  end

  always_comb begin
    adv_data    = '0;
    adv_vld     = '0;
    adv_data[0] = D;
    adv_vld[0]  = VALID_IN;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      adv_data[k] = stage_q[k-1];
      adv_vld[k]  = vld_q[k-1];
    end
  end

  // Ternaries rather than if/else so an X on a control input reaches the state.
  always_comb begin
    stage_d = SE ? chain_shift : (EN ? adv_data : stage_q);
    vld_d   = SE ? vld_q : (FLUSH ? '0 : (EN ? adv_vld : vld_q));
  end

  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      stage_q <= {DEPTH{RESET_VAL}};
      vld_q   <= '0;
    end else begin
      stage_q <= stage_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occ = occ + OW'(vld_q[k]);
    end
  end

  assign Q         = stage_q[DEPTH-1];
  assign QB        = ~stage_q[DEPTH-1];
  assign VALID_OUT = vld_q[DEPTH-1];
  assign SO        = stage_q[DEPTH-1][WIDTH-1];
  assign OCC       = occ;

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Scoreboard bench for dff_pipe_bank: a 4x2 (RESET_VAL=A) and a 1x1 (RESET_VAL=0) instance.
module tb_dff_pipe_bank;

  logic       CLK = 1'b0;
  logic       rb, en, se, si, fl, vi;
  logic [3:0] d;

  logic [3:0] q_b, qb_b;
  logic       vo_b, so_b;
  logic [1:0] occ_b;
  logic [0:0] q_s, qb_s;
  logic       vo_s, so_s;
  logic [0:0] occ_s;

  always #5 CLK = ~CLK;

  dff_pipe_bank #(.WIDTH(4), .DEPTH(2), .RESET_VAL(4'hA)) u_big (
    .CLK(CLK), .RESET_B(rb), .EN(en), .SE(se), .SI(si), .FLUSH(fl),
    .D(d), .VALID_IN(vi), .Q(q_b), .QB(qb_b), .VALID_OUT(vo_b), .SO(so_b), .OCC(occ_b)
  );

  dff_pipe_bank #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_small (
    .CLK(CLK), .RESET_B(rb), .EN(en), .SE(se), .SI(si), .FLUSH(fl),
    .D(d[0:0]), .VALID_IN(vi), .Q(q_s), .QB(qb_s), .VALID_OUT(vo_s), .SO(so_s), .OCC(occ_s)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        sel;   // 0 = 4x2 instance, 1 = 1x1 instance
    logic [3:0]  q;
    logic        v;
    logic [1:0]  occ;
    logic        so;
  } exp_t;

  exp_t        sb[$];
  string       nm_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: outputs are stable away from the rising edge.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      string       nm;
      logic [3:0]  aq, aqb, eqb;
      logic        av, aso;
      logic [1:0]  aocc;
      e  = sb.pop_front();
      nm = nm_q.pop_front();
      if (e.sel) begin
        aq = {3'b0, q_s}; aqb = {3'b0, qb_s}; eqb = {3'b0, ~e.q[0]};
        av = vo_s; aso = so_s; aocc = {1'b0, occ_s};
      end else begin
        aq = q_b; aqb = qb_b; eqb = ~e.q;
        av = vo_b; aso = so_b; aocc = occ_b;
      end
      n_vec++;
      if (aq !== e.q || aqb !== eqb || av !== e.v || aocc !== e.occ || aso !== e.so) begin
        n_bad++;
        $display("FAIL %s: got Q=%h QB=%h V=%b OCC=%0d SO=%b, want Q=%h QB=%h V=%b OCC=%0d SO=%b",
                 nm, aq, aqb, av, aocc, aso, e.q, eqb, e.v, e.occ, e.so);
      end
    end
  end

  task automatic drive(input logic rb_v, en_v, se_v, si_v, fl_v,
                       input logic [3:0] d_v, input logic vi_v);
    rb = rb_v; en = en_v; se = se_v; si = si_v; fl = fl_v; d = d_v; vi = vi_v;
  endtask

  task automatic expect_now(input logic s, input string nm, input logic [3:0] q,
                            input logic v, input logic [1:0] occ, input logic so);
    exp_t e;
    e.cyc = cyc; e.sel = s; e.q = q; e.v = v; e.occ = occ; e.so = so;
    sb.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic tick(input logic s, input string nm, input logic [3:0] q,
                      input logic v, input logic [1:0] occ, input logic so);
    @(posedge CLK);
    #1;
    expect_now(s, nm, q, v, occ, so);
  endtask

  logic [7:0]  pat;
  logic [3:0]  scan_q[8];
  logic [7:0]  scan_so;
  logic [3:0]  mid_q[3];

  initial begin
    pat     = 8'b1100_0101;
    scan_q  = '{4'hE, 4'hC, 4'h8, 4'h0, 4'h1, 4'h2, 4'h5, 4'hA};
    scan_so = 8'b1000_0111;
    mid_q   = '{4'h0, 4'h1, 4'h3};

    // Reset dominates an active EN
    drive(0, 1, 0, 0, 0, 4'h5, 1);
    tick(0, "reset", 4'hA, 0, 0, 1);

    drive(1, 1, 0, 0, 0, 4'h3, 1);
    tick(0, "adv1", 4'hA, 0, 1, 1);
    drive(1, 1, 0, 0, 0, 4'h7, 1);
    tick(0, "adv2", 4'h3, 1, 2, 0);
    drive(1, 1, 0, 0, 0, 4'h0, 0);
    tick(0, "adv3", 4'h7, 1, 1, 0);

    drive(1, 0, 0, 0, 0, 4'hF, 1);
    for (int i = 0; i < 5; i++) tick(0, "hold", 4'h7, 1, 1, 0);

    // Reset low between edges has no effect until an edge
    drive(0, 0, 0, 0, 0, 4'hF, 1);
    expect_now(0, "rst_between", 4'h7, 1, 1, 0);
    @(negedge CLK); #1;
    rb = 1'b1;

    // Scan in; last four edges also assert EN and FLUSH, which must be ignored
    for (int j = 0; j < 8; j++) begin
      drive(1, j >= 4, 1, pat[j], j >= 4, 4'hF, 1);
      tick(0, "scan", scan_q[j], 1, 1, scan_so[j]);
    end
    drive(1, 1, 0, 0, 0, 4'h0, 0);
    tick(0, "scan_stage0", 4'h3, 0, 0, 0);

    drive(1, 1, 0, 0, 0, 4'h1, 1);
    tick(0, "load1", 4'h0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 4'h2, 1);
    tick(0, "load2", 4'h1, 1, 2, 0);
    drive(1, 1, 0, 0, 1, 4'h9, 1);
    tick(0, "flush_adv", 4'h2, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 4'h0, 0);
    tick(0, "flush_stage0", 4'h9, 0, 0, 1);

    drive(1, 1, 0, 0, 0, 4'h4, 1);
    tick(0, "load3", 4'h0, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 4'hF, 1);
    tick(0, "flush_hold", 4'h0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 4'h0, 0);
    tick(0, "flush_held", 4'h4, 0, 0, 0);

    drive(1, 1, 0, 0, 0, 4'h6, 1);
    tick(0, "load4", 4'h0, 0, 1, 0);
    for (int j = 0; j < 3; j++) begin
      drive(1, 0, 1, 1, 0, 4'h0, 0);
      tick(0, "midscan", mid_q[j], 0, 1, 0);
    end
    drive(0, 1, 1, 1, 1, 4'h0, 1);
    tick(0, "rst_midscan", 4'hA, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 4'h0, 0);
    tick(0, "rst_stage0", 4'hA, 0, 0, 1);

    // 1x1 instance: latency 1, chain length 1
    drive(0, 1, 0, 1, 0, 4'h1, 1);
    tick(1, "s_reset", 4'h0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 4'h1, 1);
    tick(1, "s_adv1", 4'h1, 1, 1, 1);
    drive(1, 1, 0, 0, 0, 4'h0, 0);
    tick(1, "s_adv0", 4'h0, 0, 0, 0);
    drive(1, 1, 1, 1, 1, 4'h0, 1);
    tick(1, "s_scan1", 4'h1, 0, 0, 1);
    drive(1, 0, 1, 0, 0, 4'h1, 1);
    tick(1, "s_scan0", 4'h0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 4'h1, 1);
    tick(1, "s_load", 4'h1, 1, 1, 1);
    drive(1, 0, 1, 0, 0, 4'h1, 0);
    tick(1, "s_scan_vhold", 4'h0, 1, 1, 0);
    drive(0, 1, 1, 1, 0, 4'h1, 1);
    tick(1, "s_rst_midscan", 4'h0, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CLK);
    @(negedge CLK); #1;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_pipe_bank.md
Name: dff_pipe_bank

Overview:
- Parametrised, scan-capable register pipeline used in the 4-bit CPU datapath and its gate-level simulation.
- Each stage is a WIDTH-bit flop bank. Data advances through DEPTH stages, with a valid bit per stage and an occupancy count.
- It generalises the single-bit async-reset DFF: width, depth, clock enable, scan shift, flush, complementary outputs and occupancy tracking.
- Reset is synchronous.

Parameters:
- WIDTH, 4, bits per stage (>=1)
- DEPTH, 2, number of pipeline stages (>=1)
- RESET_VAL, 0, WIDTH-bit value loaded into every data stage on reset

Ports:
- CLK  input  1  rising-edge clock, the only clock
- RESET_B  input  1  synchronous active-low reset, sampled on rising CLK
- EN  input  1  functional advance enable
- SE  input  1  scan enable (shift mode)
- SI  input  1  scan serial input
- FLUSH  input  1  synchronously clear all valid bits
- D  input  WIDTH  data into stage 0
- VALID_IN  input  1  qualifies D
- Q  output  WIDTH  data of stage DEPTH-1
- QB  output  WIDTH  bitwise complement of Q
- VALID_OUT  output  1  valid bit of stage DEPTH-1
- SO  output  1  scan out = stage DEPTH-1 bit WIDTH-1
- OCC  output  $clog2(DEPTH+1)  number of set valid bits

Behaviour:
- State is stage[0..DEPTH-1] (WIDTH bits each) and vld[0..DEPTH-1].
- All state updates occur on rising CLK only. Outputs are direct functions of the registers, with no combinational path from any input.
- Priority at each edge, highest first: reset, then SE, then FLUSH, then EN, then hold.
- Reset (RESET_B=0 at the edge):
  - every stage loads RESET_VAL and every vld clears.
  - After reset: Q=RESET_VAL, QB=~RESET_VAL, VALID_OUT=0, OCC=0, SO=RESET_VAL[WIDTH-1].
  - Reset mid-operation (including mid-scan) discards all contents at that edge.
  - No asynchronous effect: between edges, outputs keep their last values while RESET_B is low.
- Scan (SE=1):
  - The chain order is SI -> stage0[0] -> stage0[1] -> ... -> stage0[WIDTH-1] -> stage1[0] -> ... -> stage[DEPTH-1][WIDTH-1] -> SO.
  - Each edge shifts one position. Chain length is WIDTH*DEPTH.
  - vld bits are not in the chain and hold.
  - EN, FLUSH, D and VALID_IN are ignored.
- Flush (SE=0, FLUSH=1):
  - all vld clear.
  - If EN=1, data still advances as in the advance rule below (VALID_IN is ignored, so stage 0 valid is 0). If EN=0, data holds.
  - OCC=0 after the edge.
- Advance (SE=0, FLUSH=0, EN=1): stage0<=D, vld0<=VALID_IN, and stage k<=stage k-1, vld k<=vld k-1 for k>=1.
  - Data written with EN=1 appears on Q exactly DEPTH edges later, given DEPTH consecutive EN=1 edges.
  - Data in the last stage is overwritten; there is no back-pressure.
- Hold (SE=0, FLUSH=0, EN=0): all state unchanged.
- OCC is the population count of vld; its range is 0..DEPTH.
- DEPTH=1 degenerates to a single enabled flop bank; SO is then stage0[WIDTH-1].
- X on EN/SE/FLUSH must not be masked: simulation should propagate X into state (no default-to-hold coding).

Test Plan (WIDTH=4, DEPTH=2, RESET_VAL=4'hA unless stated):
- Reset: RESET_B=0 for 1 edge with EN=1, D=4'h5 -> Q=4'hA, QB=4'h5, VALID_OUT=0, OCC=0, SO=1. Drive RESET_B=0 between edges -> outputs unchanged until the next edge.
- Pipeline and hold:
  - EN=1, D=3 then 7, VALID_IN=1,1 -> after edge 2: Q=3, VALID_OUT=1, OCC=2; after edge 3 (D=0, VALID_IN=0): Q=7, OCC=1.
  - EN=0 for 5 edges -> Q stays 7, OCC stays 1.
- Scan:
  - Scan shift in pattern 8'b1100_0101, bit0 first, SE=1 for 8 edges -> stage0=4'h3, stage1=4'hA. SO over those 8 edges emits the prior contents MSB-chain-first.
  - vld bits and OCC are unchanged throughout.
- Flush with advance: load 2 valid entries (OCC=2), then FLUSH=1, EN=1, D=9, VALID_IN=1 -> OCC=0, VALID_OUT=0, stage0=9.
- Simultaneous SE=1, FLUSH=1, EN=1 -> only the scan shift happens; OCC unchanged.
- Reset mid-scan: after 3 scan edges, RESET_B=0 -> all stages return to 4'hA, OCC=0. Repeat with DEPTH=1, WIDTH=1, RESET_VAL=0 -> latency 1, chain length 1.
